simple_threshold_mac_pipe: RTL and testbench
============================================

Name: simple_threshold_mac_pipe

Overview:
Parametrised, pipelined successor to the single-cycle threshold multiplier. It multiplies two operands with a configurable pipeline depth and selectable signedness, saturates to the output width, and can optionally accumulate a group of products (for example price × quantity sums) into one result. It sits between the tick-decode stage and the threshold comparator, with valid/ready handshakes on both sides.

Parameters:
ID, 1, instance tag, no functional effect
NUM_STAGE, 3, beat latency in cycles from input accept to out_valid, legal range 1..6
din0_WIDTH, 16, operand 0 width
din1_WIDTH, 10, operand 1 width
dout_WIDTH, 24, result and accumulator width
SIGNED, 0, 0 = unsigned operands (zero-extended), 1 = two's-complement operands

Ports:
ap_clk  in  1  clock, rising edge
ap_rst  in  1  asynchronous reset, active-high
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
din0  in  din0_WIDTH  operand 0
din1  in  din1_WIDTH  operand 1
acc_en  in  1  1 = this beat joins the accumulation group
in_last  in  1  closes the group; only meaningful when acc_en=1
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
dout  out  dout_WIDTH  saturated product or group sum
dout_sat  out  1  result was clamped (sticky across the group)

Behaviour:
- Reset is asynchronous and active-high. While ap_rst=1: every stage valid bit = 0, out_valid = 0, dout = 0, dout_sat = 0, accumulator = 0, accumulator sat flag = 0. in_ready = 1 after reset is released.
- Handshake and stall:
  - ce = !out_valid | out_ready; in_ready = ce.
  - A beat is accepted when in_valid & in_ready.
  - When ce = 0, every pipeline register holds its value, including data, valid bits and the accumulator.
  - dout and dout_sat stay stable while out_valid=1 and out_ready=0.
- Latency: an accepted beat that produces output sets out_valid exactly NUM_STAGE ce-cycles after acceptance. Throughput is 1 beat per cycle when there is no stall.
- Arithmetic:
  - Full product P has width din0_WIDTH + din1_WIDTH, computed with no truncation.
  - SIGNED=0: operands are zero-extended. SIGNED=1: operands are sign-extended.
  - The multiply is registered in stage 1; the remaining stages are retiming registers.
  - Saturation, unsigned: clamp to 2^dout_WIDTH − 1.
  - Saturation, signed: clamp to [−2^(dout_WIDTH−1), 2^(dout_WIDTH−1) − 1].
  - Whenever a value is clamped, dout_sat = 1.
- Modes, evaluated at the final stage:
  - acc_en=0: the beat emits its own saturated product. The accumulator is untouched, and any open group stays open. in_last is ignored.
  - acc_en=1, in_last=0: acc = sat(acc + P). The accumulator sat flag ORs in any clamp. No output is produced.
  - acc_en=1, in_last=1: the block emits sat(acc + P) with dout_sat = (sticky flag | clamp). The same cycle clears acc and the sticky flag to 0.
  - A group of one (first beat carries in_last) emits sat(P).
- The accumulator uses dout_WIDTH + 1 guard bits internally, so overflow is detected before clamping.
- Reset mid-group discards the partial sum and any in-flight beats. No output is produced for them.
- The block never drops or reorders beats. Results leave in acceptance order.

Decomposition:
- Shared package simple_threshold_pkg holds:
  - saturation min/max constant functions, parametrised by width and signedness
  - the stage-valid/data bundle typedef (valid, acc_en, last, product)
- One sub-module: simple_threshold_sat_add. It is combinational: width-extended add followed by clamp, with a sat output. It is used by both the product-only path and the accumulate path.
- Pipeline control (ce, valid shift) lives in the top level.

Test Plan:
1. Defaults, acc_en=0, din0=1000, din1=1000, out_ready=1 → exactly 3 cycles later out_valid=1, dout=1000000, dout_sat=0.
2. Defaults, acc_en=0, din0=65535, din1=1023 (P=67042305) → dout=16777215, dout_sat=1.
3. acc_en=1 beats (100,10), (200,10), (300,10,last) back-to-back → exactly one output, dout=6000, dout_sat=0. Then (10000,1000) ×2 with last on the second → dout=16777215, dout_sat=1, and the sticky flag is cleared for the next group.
4. Stream 4 beats (1,1)..(4,4) with out_ready=0 for 5 cycles from first out_valid → in_ready=0 during the stall, dout held. After release, outputs are 1, 4, 9, 16 in order with none lost.
5. Assert ap_rst asynchronously after 2 beats of an open group → out_valid and dout drop to 0 immediately. Next group (5,5,last) → dout=25.
6. SIGNED=1, din0=−3, din1=7 → dout=−21. din0=−32768, din1=−512 (P=16777216) → dout=8388607, dout_sat=1.

Source files
------------

// File: rtl/simple_threshold_pkg.sv
// Shared saturation limits and the per-stage beat bundle for the threshold MAC pipeline.
package simple_threshold_pkg;

  localparam int PROD_MAX_W = 64;
  localparam int SAT_CALC_W = 128;

  typedef logic signed [SAT_CALC_W-1:0] sat_val_t;

  // Product is carried sign/zero-extended to full width so the final stage sees a ready-to-add value.
  typedef struct packed {
    logic                  valid;
    logic                  acc_en;
    logic                  last;
    logic [PROD_MAX_W-1:0] product;
  } stage_t;

  function automatic sat_val_t sat_max(input int width, input bit is_signed);
    if (is_signed) return (sat_val_t'(1) <<< (width - 1)) - sat_val_t'(1);
    return (sat_val_t'(1) <<< width) - sat_val_t'(1);
  endfunction

  function automatic sat_val_t sat_min(input int width, input bit is_signed);
    if (is_signed) return -(sat_val_t'(1) <<< (width - 1));
    return '0;
  endfunction

endpackage

// File: rtl/simple_threshold_sat_add.sv
// Combinational add in a widened domain followed by a clamp to the output range.
module simple_threshold_sat_add #(
  parameter int A_W    = 24,
  parameter int B_W    = 64,
  parameter int O_W    = 24,
  parameter bit SIGNED = 1'b0
) (
  input  logic [A_W-1:0] i_a,
  input  logic [B_W-1:0] i_b,
  output logic [O_W-1:0] o_y,
  output logic           o_sat
);
  import simple_threshold_pkg::*;

  localparam int MW = (A_W > B_W) ? ((A_W > O_W) ? A_W : O_W) : ((B_W > O_W) ? B_W : O_W);
  localparam int EW = MW + 2;
  localparam logic signed [EW-1:0] MAX_V = EW'(sat_max(O_W, SIGNED));
  localparam logic signed [EW-1:0] MIN_V = EW'(sat_min(O_W, SIGNED));

  logic signed [EW-1:0] w_a_ext;
  logic signed [EW-1:0] w_b_ext;
  logic signed [EW-1:0] w_sum;

  always_comb begin
    w_a_ext = SIGNED ? EW'($signed(i_a)) : EW'(i_a);
    w_b_ext = SIGNED ? EW'($signed(i_b)) : EW'(i_b);
    w_sum   = w_a_ext + w_b_ext;
    o_sat   = (w_sum > MAX_V) || (w_sum < MIN_V);
    if (w_sum > MAX_V)      o_y = MAX_V[O_W-1:0];
    else if (w_sum < MIN_V) o_y = MIN_V[O_W-1:0];
    else                    o_y = w_sum[O_W-1:0];
  end

endmodule

// File: rtl/simple_threshold_mac_pipe.sv
// Pipelined saturating multiplier with optional group accumulation and valid/ready flow control.
module simple_threshold_mac_pipe #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 10,
  parameter int dout_WIDTH = 24,
  parameter int SIGNED     = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  acc_en,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  dout_sat
);
  import simple_threshold_pkg::*;

  logic                  w_ce;
  logic [PROD_MAX_W-1:0] w_a_ext;
  logic [PROD_MAX_W-1:0] w_b_ext;
  stage_t                w_in;
  stage_t                w_fin;
  logic [dout_WIDTH-1:0] w_acc_sel;
  logic [dout_WIDTH-1:0] w_sum;
  logic                  w_clamp;

  logic                  r_out_valid;
  logic [dout_WIDTH-1:0] r_dout;
  logic                  r_dout_sat;
  logic [dout_WIDTH-1:0] r_acc;
  logic                  r_acc_sat;

  assign w_ce      = !r_out_valid || out_ready;
  assign in_ready  = w_ce;
  assign out_valid = r_out_valid;
  assign dout      = r_dout;
  assign dout_sat  = r_dout_sat;

  // Modular 64-bit multiply of extended operands yields the exact product in two's complement.
  always_comb begin
    w_a_ext        = (SIGNED != 0) ? PROD_MAX_W'($signed(din0)) : PROD_MAX_W'(din0);
    w_b_ext        = (SIGNED != 0) ? PROD_MAX_W'($signed(din1)) : PROD_MAX_W'(din1);
    w_in.valid     = in_valid;
    w_in.acc_en    = acc_en;
    w_in.last      = in_last;
    w_in.product   = w_a_ext * w_b_ext;
  end

  if (NUM_STAGE > 1) begin : g_pipe
    stage_t r_pipe [NUM_STAGE-1];

    always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
        for (int i = 0; i < NUM_STAGE - 1; i++) r_pipe[i] <= '0;
      end else if (w_ce) begin
        r_pipe[0] <= w_in;
        for (int i = 1; i < NUM_STAGE - 1; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end

    assign w_fin = r_pipe[NUM_STAGE-2];
  end else begin : g_direct
    assign w_fin = w_in;
  end

  assign w_acc_sel = w_fin.acc_en ? r_acc : '0;

  simple_threshold_sat_add #(
    .A_W   (dout_WIDTH),
    .B_W   (PROD_MAX_W),
    .O_W   (dout_WIDTH),
    .SIGNED(SIGNED != 0)
  ) u_sat_add (
    .i_a  (w_acc_sel),
    .i_b  (w_fin.product),
    .o_y  (w_sum),
    .o_sat(w_clamp)
  );

  // Output register doubles as the last pipeline stage; the accumulator advances only on ce.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_out_valid <= 1'b0;
      r_dout      <= '0;
      r_dout_sat  <= 1'b0;
      r_acc       <= '0;
      r_acc_sat   <= 1'b0;
    end else if (w_ce) begin
      r_out_valid <= 1'b0;
      if (w_fin.valid) begin
        if (!w_fin.acc_en) begin
          r_out_valid <= 1'b1;
          r_dout      <= w_sum;
          r_dout_sat  <= w_clamp;
        end else if (!w_fin.last) begin
          r_acc       <= w_sum;
          r_acc_sat   <= r_acc_sat | w_clamp;
        end else begin
          r_out_valid <= 1'b1;
          r_dout      <= w_sum;
          r_dout_sat  <= r_acc_sat | w_clamp;
          r_acc       <= '0;
          r_acc_sat   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_simple_threshold_mac_pipe.sv
// Self-checking bench: unsigned and signed instances checked against an arithmetic reference model.
module tb_simple_threshold_mac_pipe;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b0;
  always #5 ap_clk = ~ap_clk;

  logic        u_in_valid, u_in_ready, u_acc_en, u_in_last, u_out_valid, u_out_ready, u_dout_sat;
  logic [15:0] u_din0;
  logic [9:0]  u_din1;
  logic [23:0] u_dout;
  logic        s_in_valid, s_in_ready, s_acc_en, s_in_last, s_out_valid, s_out_ready, s_dout_sat;
  logic [15:0] s_din0;
  logic [9:0]  s_din1;
  logic [23:0] s_dout;

  simple_threshold_mac_pipe #(.SIGNED(0)) dut_u (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(u_in_valid), .in_ready(u_in_ready),
    .din0(u_din0), .din1(u_din1), .acc_en(u_acc_en), .in_last(u_in_last),
    .out_valid(u_out_valid), .out_ready(u_out_ready), .dout(u_dout), .dout_sat(u_dout_sat));

  simple_threshold_mac_pipe #(.SIGNED(1)) dut_s (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .din0(s_din0), .din1(s_din1), .acc_en(s_acc_en), .in_last(s_in_last),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .dout(s_dout), .dout_sat(s_dout_sat));

  typedef struct {
    logic [23:0] d;
    logic        s;
  } exp_t;

  exp_t   q_u[$];
  exp_t   q_s[$];
  longint m_acc[2];
  bit     m_sat[2];
  int     total = 0;
  int     bad   = 0;

  function automatic longint clamp24(input longint v, input bit sg, output bit c);
    longint hi, lo;
    hi = sg ? 64'sd8388607 : 64'sd16777215;
    lo = sg ? -64'sd8388608 : 64'sd0;
    c  = (v > hi) || (v < lo);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int qsize(input bit sel);
    return sel ? q_s.size() : q_u.size();
  endfunction

  task automatic model_push(input bit sel, input logic [15:0] a, input logic [9:0] b,
                            input bit ae, input bit lst);
    longint p, v;
    bit     c;
    exp_t   e;
    p = sel ? longint'($signed(a)) * longint'($signed(b)) : longint'(a) * longint'(b);
    if (!ae) begin
      v = clamp24(p, sel, c);
      e.d = v[23:0];
      e.s = c;
      if (sel) q_s.push_back(e); else q_u.push_back(e);
    end else begin
      v = clamp24(m_acc[sel] + p, sel, c);
      if (!lst) begin
        m_acc[sel] = v;
        m_sat[sel] = m_sat[sel] | c;
      end else begin
        e.d = v[23:0];
        e.s = m_sat[sel] | c;
        if (sel) q_s.push_back(e); else q_u.push_back(e);
        m_acc[sel] = 0;
        m_sat[sel] = 1'b0;
      end
    end
  endtask

  task automatic model_clear();
    q_u.delete();
    q_s.delete();
    m_acc[0] = 0; m_acc[1] = 0;
    m_sat[0] = 1'b0; m_sat[1] = 1'b0;
  endtask

  task automatic pop_exp(input bit sel, output bit ok, output exp_t e);
    ok = (qsize(sel) > 0);
    e.d = 'x;
    e.s = 'x;
    if (ok) e = sel ? q_s.pop_front() : q_u.pop_front();
  endtask

  // One clock: drive at posedge+1, sample at negedge, update the model on acceptance.
  task automatic step(input bit sel, input bit v, input logic [15:0] a, input logic [9:0] b,
                      input bit ae, input bit lst, input bit ordy,
                      output bit ov, output bit rdy, output logic [23:0] d, output bit s);
    if (sel) begin
      s_in_valid = v; s_din0 = a; s_din1 = b; s_acc_en = ae; s_in_last = lst; s_out_ready = ordy;
    end else begin
      u_in_valid = v; u_din0 = a; u_din1 = b; u_acc_en = ae; u_in_last = lst; u_out_ready = ordy;
    end
    @(negedge ap_clk);
    if (sel) begin
      ov = s_out_valid; rdy = s_in_ready; d = s_dout; s = s_dout_sat;
    end else begin
      ov = u_out_valid; rdy = u_in_ready; d = u_dout; s = u_dout_sat;
    end
    if (v && rdy) model_push(sel, a, b, ae, lst);
    @(posedge ap_clk);
    #1;
  endtask

  task automatic test_reset();
    u_in_valid = 0; u_din0 = 0; u_din1 = 0; u_acc_en = 0; u_in_last = 0; u_out_ready = 1;
    s_in_valid = 0; s_din0 = 0; s_din1 = 0; s_acc_en = 0; s_in_last = 0; s_out_ready = 1;
    #2 ap_rst = 1'b1;
    #10;
    total++;
    if (u_out_valid !== 1'b0 || u_dout !== 24'd0 || u_dout_sat !== 1'b0 || s_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: out_valid=%b dout=%0h sat=%b s_out_valid=%b, required 0/0/0/0",
               u_out_valid, u_dout, u_dout_sat, s_out_valid);
    end
    model_clear();
    @(negedge ap_clk) ap_rst = 1'b0;
    @(posedge ap_clk);
    #1;
    total++;
    if (u_in_ready !== 1'b1 || s_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: u=%b s=%b, required 1", u_in_ready, s_in_ready);
    end
  endtask

  task automatic test_product();
    bit ov, rdy, s, ok;
    logic [23:0] d;
    exp_t e;
    int lat = -1;
    step(0, 1, 16'd1000, 10'd1000, 0, 0, 1, ov, rdy, d, s);
    for (int k = 1; k <= 8; k++) begin
      step(0, 0, 16'd0, 10'd0, 0, 0, 1, ov, rdy, d, s);
      if (ov) begin
        if (lat < 0) lat = k;
        pop_exp(0, ok, e);
        total++;
        if (!ok || d !== e.d || s !== e.s) begin
          bad++;
          $display("FAIL product_1000x1000: dout=%0d sat=%b, required dout=%0d sat=%b", d, s, e.d, e.s);
        end
      end
    end
    total++;
    if (lat != 3) begin
      bad++;
      $display("FAIL latency: got %0d cycles, required 3", lat);
    end
    step(0, 1, 16'd65535, 10'd1023, 0, 0, 1, ov, rdy, d, s);
    for (int k = 1; k <= 6; k++) begin
      step(0, 0, 16'd0, 10'd0, 0, 0, 1, ov, rdy, d, s);
      if (ov) begin
        pop_exp(0, ok, e);
        total++;
        if (!ok || d !== e.d || s !== e.s || d !== 24'd16777215) begin
          bad++;
          $display("FAIL product_sat: dout=%0d sat=%b, required dout=%0d sat=%b", d, s, e.d, e.s);
        end
      end
    end
    total++;
    if (qsize(0) != 0) begin
      bad++;
      $display("FAIL product_missing: %0d results never appeared, required 0", qsize(0));
    end
  endtask

  task automatic test_group();
    logic [15:0] ta [6] = '{16'd100, 16'd200, 16'd300, 16'd10000, 16'd10000, 16'd1};
    logic [9:0]  tb [6] = '{10'd10, 10'd10, 10'd10, 10'd1000, 10'd1000, 10'd1};
    bit          tl [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    bit ov, rdy, s, ok;
    logic [23:0] d;
    exp_t e;
    int i = 0, j, fires = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      j = (i < 6) ? i : 5;
      step(0, i < 6, ta[j], tb[j], 1, tl[j], 1, ov, rdy, d, s);
      if (i < 6 && rdy) i++;
      if (ov) begin
        fires++;
        pop_exp(0, ok, e);
        total++;
        if (!ok || d !== e.d || s !== e.s) begin
          bad++;
          $display("FAIL group_result: dout=%0d sat=%b, required dout=%0d sat=%b", d, s, e.d, e.s);
        end
      end
    end
    total++;
    if (fires != 3 || qsize(0) != 0) begin
      bad++;
      $display("FAIL group_count: %0d outputs (%0d pending), required 3 (0)", fires, qsize(0));
    end
  endtask

  task automatic test_stall();
    bit ov, rdy, s, ok, seen = 0;
    logic [23:0] d;
    exp_t e;
    int i = 0, stall = 0, fires = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (!seen && u_out_valid) begin
        seen  = 1;
        stall = 5;
      end
      step(0, i < 4, 16'(i + 1), 10'(i + 1), 0, 0, stall == 0, ov, rdy, d, s);
      if (i < 4 && rdy) i++;
      if (stall > 0) begin
        total++;
        if (rdy !== 1'b0 || ov !== 1'b1 || d !== 24'd1) begin
          bad++;
          $display("FAIL stall_hold: in_ready=%b out_valid=%b dout=%0d, required 0/1/1", rdy, ov, d);
        end
        stall--;
      end else if (ov) begin
        fires++;
        pop_exp(0, ok, e);
        total++;
        if (!ok || d !== e.d || s !== e.s) begin
          bad++;
          $display("FAIL stall_order: dout=%0d sat=%b, required dout=%0d sat=%b", d, s, e.d, e.s);
        end
      end
    end
    total++;
    if (fires != 4 || qsize(0) != 0) begin
      bad++;
      $display("FAIL stall_count: %0d outputs (%0d pending), required 4 (0)", fires, qsize(0));
    end
  endtask

  task automatic test_reset_mid();
    bit ov, rdy, s, ok;
    logic [23:0] d;
    exp_t e;
    int fires = 0;
    step(0, 1, 16'd2, 10'd3, 1, 0, 1, ov, rdy, d, s);
    step(0, 1, 16'd4, 10'd5, 1, 0, 1, ov, rdy, d, s);
    step(0, 1, 16'd7, 10'd7, 0, 0, 1, ov, rdy, d, s);
    step(0, 0, 16'd0, 10'd0, 0, 0, 1, ov, rdy, d, s);
    step(0, 0, 16'd0, 10'd0, 0, 0, 1, ov, rdy, d, s);
    u_in_valid  = 0;
    u_out_ready = 0;
    #2;
    total++;
    if (u_out_valid !== 1'b1 || u_dout !== 24'd49) begin
      bad++;
      $display("FAIL pre_reset_output: out_valid=%b dout=%0d, required 1/49", u_out_valid, u_dout);
    end
    ap_rst = 1'b1;
    #1;
    total++;
    if (u_out_valid !== 1'b0 || u_dout !== 24'd0 || u_dout_sat !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: out_valid=%b dout=%0d sat=%b, required 0/0/0", u_out_valid, u_dout, u_dout_sat);
    end
    model_clear();
    @(negedge ap_clk) ap_rst = 1'b0;
    @(posedge ap_clk);
    #1;
    step(0, 1, 16'd5, 10'd5, 1, 1, 1, ov, rdy, d, s);
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 16'd0, 10'd0, 0, 0, 1, ov, rdy, d, s);
      if (ov) begin
        fires++;
        pop_exp(0, ok, e);
        total++;
        if (!ok || d !== e.d || s !== e.s || d !== 24'd25) begin
          bad++;
          $display("FAIL after_reset_group: dout=%0d sat=%b, required dout=25 sat=0", d, s);
        end
      end
    end
    total++;
    if (fires != 1) begin
      bad++;
      $display("FAIL after_reset_count: %0d outputs, required 1", fires);
    end
  endtask

  task automatic test_signed();
    logic [15:0] ta [4] = '{16'hFFFD, 16'h8000, 16'hFFFD, 16'hFFFD};
    logic [9:0]  tb [4] = '{10'd7, 10'h200, 10'd7, 10'd7};
    bit          te [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    bit          tl [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    bit ov, rdy, s, ok;
    logic [23:0] d;
    exp_t e;
    int i = 0, j, fires = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      j = (i < 4) ? i : 3;
      step(1, i < 4, ta[j], tb[j], te[j], tl[j], 1, ov, rdy, d, s);
      if (i < 4 && rdy) i++;
      if (ov) begin
        fires++;
        pop_exp(1, ok, e);
        total++;
        if (!ok || d !== e.d || s !== e.s) begin
          bad++;
          $display("FAIL signed_result: dout=%0h sat=%b, required dout=%0h sat=%b", d, s, e.d, e.s);
        end
      end
    end
    total++;
    if (fires != 3 || qsize(1) != 0) begin
      bad++;
      $display("FAIL signed_count: %0d outputs (%0d pending), required 3 (0)", fires, qsize(1));
    end
  endtask

  task automatic test_random(input bit sel);
    bit ov, rdy, s, ok, v, ordy, ae, l;
    logic [23:0] d;
    logic [15:0] a;
    logic [9:0]  b;
    exp_t e;
    for (int cyc = 0; cyc < 400; cyc++) begin
      v    = ($urandom_range(0, 9) < 7) && (cyc < 360);
      ordy = ($urandom_range(0, 3) != 0) || (cyc >= 360);
      a    = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'($urandom_range(0, 3000));
      b    = 10'($urandom);
      ae   = 1'($urandom_range(0, 1));
      l    = ($urandom_range(0, 3) == 0);
      step(sel, v, a, b, ae, l, ordy, ov, rdy, d, s);
      if (ov && ordy) begin
        pop_exp(sel, ok, e);
        total++;
        if (!ok || d !== e.d || s !== e.s) begin
          bad++;
          $display("FAIL random_sel%0d: cycle %0d dout=%0h sat=%b, required dout=%0h sat=%b",
                   sel, cyc, d, s, e.d, e.s);
        end
      end
    end
    total++;
    if (qsize(sel) != 0) begin
      bad++;
      $display("FAIL random_drain_sel%0d: %0d results never appeared, required 0", sel, qsize(sel));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time limit, required finish");
    $fatal(1, "time limit reached");
  end

  initial begin
    test_reset();
    test_product();
    test_group();
    test_stall();
    test_reset_mid();
    test_signed();
    test_random(1'b0);
    test_random(1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
